// File: rtl/code_loader.sv
// code_loader: streams big-endian byte pairs into code memory from address 0 while holding the CPU
// Optional feature macro: LOADER_CHECKSUM_EN (adds the trailing XOR checksum byte and CHK state)
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   start                  begins a load when idle
//   byte_valid, byte_data  byte stream in; byte_ready accepts it
//   mem_w_en, mem_addr, mem_d_in  code-memory write port
//   busy, cpu_hold         load in progress
//   done, error            sticky result of the last load
module code_loader #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              mem_w_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_d_in,
  output logic              busy,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);
  typedef enum logic [3:0] {
    IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, WRITE,
`ifdef LOADER_CHECKSUM_EN
    CHK,
`endif
    DONE, FAIL
  } state_t;
`ifdef LOADER_CHECKSUM_EN
  localparam state_t TAIL = CHK;
`else
  localparam state_t TAIL = DONE;
`endif
  // Any length above capacity, including one with stray upper bits, is rejected
  localparam logic [15:0] CAP = 16'(1 << ADDR_W);
  state_t state, nxt;
  logic [7:0] len_hi;
  logic [ADDR_W:0] n, cnt, cnt_inc;
  logic [15:0] len;
  logic take, chk_st;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0] acc;
  assign chk_st = state == CHK;
`else
  assign chk_st = 1'b0;
`endif
  assign len = {len_hi, byte_data};
  assign cnt_inc = cnt + (ADDR_W+1)'(1);
  assign take = byte_valid && byte_ready;
  // The address is the low bits of the word count, so it wraps to 0 after a full load
  assign mem_addr = cnt[ADDR_W-1:0];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    byte_ready = state inside {LEN_HI, LEN_LO, DATA_HI, DATA_LO} || chk_st;
    mem_w_en = state == WRITE;
    busy = byte_ready || mem_w_en;
    cpu_hold = busy;
    case (state)
      IDLE:    nxt = start ? LEN_HI : IDLE;
      LEN_HI:  nxt = take ? LEN_LO : LEN_HI;
      LEN_LO:  nxt = !take ? LEN_LO : (len > CAP) ? FAIL : (len == 16'd0) ? TAIL : DATA_HI;
      DATA_HI: nxt = take ? DATA_LO : DATA_HI;
      DATA_LO: nxt = take ? WRITE : DATA_LO;
      WRITE:   nxt = (cnt_inc == n) ? TAIL : DATA_HI;
`ifdef LOADER_CHECKSUM_EN
      CHK:     nxt = !take ? CHK : (byte_data == acc) ? DONE : FAIL;
`endif
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      len_hi <= '0;
      n <= '0;
      cnt <= '0;
      mem_d_in <= '0;
      done <= 1'b0;
      error <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      acc <= '0;
`endif
    end else begin
      if (state == IDLE && start) begin
        done <= 1'b0;
        error <= 1'b0;
        cnt <= '0;
`ifdef LOADER_CHECKSUM_EN
        acc <= '0;
`endif
      end
      if (nxt == DONE) done <= 1'b1;
      if (nxt == FAIL) error <= 1'b1;
      if (state == WRITE) cnt <= cnt_inc;
      if (take && state == LEN_HI) len_hi <= byte_data;
      if (take && state == LEN_LO) n <= len[ADDR_W:0];
      if (take && state == DATA_HI) mem_d_in[DATA_W-1:DATA_W-8] <= byte_data;
      if (take && state == DATA_LO) mem_d_in[7:0] <= byte_data;
`ifdef LOADER_CHECKSUM_EN
      if (take && !chk_st) acc <= acc ^ byte_data;
`endif
    end
endmodule

// File: tb/tb_code_loader.sv
// tb_code_loader: directed self-checking bench for code_loader
module tb_code_loader;
  typedef logic [7:0] bq_t[$];
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, byte_valid = 1'b0;
  logic [7:0] byte_data = 8'h00;
  logic byte_ready, mem_w_en, busy, cpu_hold, done, error;
  logic [8:0] mem_addr;
  logic [15:0] mem_d_in;
  int pass = 0, total = 0;
  int wcount = 0;
  logic [8:0] wa [2048];
  logic [15:0] wd [2048];
`ifdef LOADER_CHECKSUM_EN
  localparam int CK = 1;
`else
  localparam int CK = 0;
`endif

  code_loader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(byte_ready), .mem_w_en(mem_w_en), .mem_addr(mem_addr), .mem_d_in(mem_d_in),
    .busy(busy), .cpu_hold(cpu_hold), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  // Write log: memory samples the write port once per write cycle
  always @(negedge clk)
    if (mem_w_en && wcount < 2048) begin
      wa[wcount] = mem_addr;
      wd[wcount] = mem_d_in;
      wcount = wcount + 1;
    end

  function automatic bq_t with_chk(input bq_t q);
`ifdef LOADER_CHECKSUM_EN
    logic [7:0] x = 8'h00;
    foreach (q[i]) x ^= q[i];
    q.push_back(x);
`endif
    return q;
  endfunction

  // cyc = rising edges from the start edge (counted as 1) until done/error is seen
  task automatic load(input bq_t q, input bit toggle, input bit hold_start, input int abort_at, output int cyc);
    int i;
    bit ph;
    bit acc;
    i = 0;
    ph = 1'b0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = hold_start; cyc = 1;
    while (!(done || error) && cyc < 4000) begin
      if (abort_at == cyc) begin
        rst_n = 1'b0;
        byte_valid = 1'b0;
        start = 1'b0;
        #1;
        return;
      end
      ph = ~ph;
      byte_valid = (i < q.size()) && (ph || !toggle);
      byte_data = (i < q.size()) ? q[i] : 8'h00;
      acc = byte_valid && byte_ready;
      @(posedge clk);
      if (acc) i++;
      @(negedge clk);
      cyc++;
    end
    byte_valid = 1'b0;
    start = 1'b0;
  endtask

  task automatic test_reset;
    #1;
    total++;
    if ({byte_ready, mem_w_en, busy, cpu_hold, done, error} !== 6'b0)
      $display("FAIL reset_flags got %b want 000000", {byte_ready, mem_w_en, busy, cpu_hold, done, error});
    else pass++;
    total++;
    if ({mem_addr, mem_d_in} !== 25'h0) $display("FAIL reset_bus got %h want 0", {mem_addr, mem_d_in});
    else pass++;
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_two_words;
    bq_t q;
    int cyc, w0;
    q = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
    w0 = wcount;
    load(with_chk(q), 1'b0, 1'b0, 0, cyc);
    total++;
    if (cyc !== 9 + CK) $display("FAIL two_latency got %0d want %0d", cyc, 9 + CK); else pass++;
    total++;
    if ({done, error, busy, cpu_hold} !== 4'b1000) $display("FAIL two_flags got %b want 1000", {done, error, busy, cpu_hold}); else pass++;
    total++;
    if (wcount - w0 !== 2) $display("FAIL two_count got %0d want 2", wcount - w0); else pass++;
    total++;
    if ({wa[w0], wd[w0]} !== {9'd0, 16'h1234}) $display("FAIL two_w0 got %h:%h want 0:1234", wa[w0], wd[w0]); else pass++;
    total++;
    if ({wa[w0+1], wd[w0+1]} !== {9'd1, 16'hABCD}) $display("FAIL two_w1 got %h:%h want 1:abcd", wa[w0+1], wd[w0+1]); else pass++;
  endtask

  task automatic test_backpressure;
    bq_t q;
    int cyc, w0;
    q = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
    w0 = wcount;
    load(with_chk(q), 1'b1, 1'b1, 0, cyc);
    total++;
    if ({done, error} !== 2'b10) $display("FAIL bp_flags got %b want 10", {done, error}); else pass++;
    total++;
    if (wcount - w0 !== 2) $display("FAIL bp_count got %0d want 2", wcount - w0); else pass++;
    total++;
    if ({wa[w0], wd[w0], wa[w0+1], wd[w0+1]} !== {9'd0, 16'h1234, 9'd1, 16'hABCD})
      $display("FAIL bp_data got %h:%h %h:%h want 0:1234 1:abcd", wa[w0], wd[w0], wa[w0+1], wd[w0+1]);
    else pass++;
    @(negedge clk); @(negedge clk);
    total++;
    if ({done, busy} !== 2'b10) $display("FAIL bp_start_ignored got %b want 10", {done, busy}); else pass++;
  endtask

  task automatic test_oversize;
    bq_t q;
    int cyc, w0;
    q = '{8'h02, 8'h01};
    w0 = wcount;
    load(q, 1'b0, 1'b0, 0, cyc);
    total++;
    if (cyc !== 3) $display("FAIL over_latency got %0d want 3", cyc); else pass++;
    total++;
    if ({error, done, busy} !== 3'b100) $display("FAIL over_flags got %b want 100", {error, done, busy}); else pass++;
    total++;
    if (wcount - w0 !== 0) $display("FAIL over_writes got %0d want 0", wcount - w0); else pass++;
    @(negedge clk);
  endtask

  task automatic test_full;
    bq_t q;
    int cyc, w0, bad;
    q = '{8'h02, 8'h00};
    for (int i = 0; i < 512; i++) begin
      q.push_back(8'(i >> 8));
      q.push_back(8'(i));
    end
    w0 = wcount;
    load(with_chk(q), 1'b0, 1'b0, 0, cyc);
    total++;
    if (cyc !== 1539 + CK) $display("FAIL full_latency got %0d want %0d", cyc, 1539 + CK); else pass++;
    total++;
    if ({done, error} !== 2'b10) $display("FAIL full_flags got %b want 10", {done, error}); else pass++;
    total++;
    if (wcount - w0 !== 512) $display("FAIL full_count got %0d want 512", wcount - w0); else pass++;
    total++;
    if ({wa[w0+511], wd[w0+511]} !== {9'd511, 16'h01FF}) $display("FAIL full_last got %h:%h want 1ff:01ff", wa[w0+511], wd[w0+511]); else pass++;
    bad = 0;
    for (int i = 0; i < 512; i++) if (wa[w0+i] !== 9'(i) || wd[w0+i] !== 16'(i)) bad++;
    total++;
    if (bad !== 0) $display("FAIL full_words got %0d bad want 0", bad); else pass++;
    total++;
    if (mem_addr !== 9'd0) $display("FAIL full_wrap got %h want 0", mem_addr); else pass++;
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic test_bad_checksum;
    bq_t q;
    int cyc, w0;
    q = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h7D};
    w0 = wcount;
    load(q, 1'b0, 1'b0, 0, cyc);
    total++;
    if ({error, done} !== 2'b10) $display("FAIL chk_flags got %b want 10", {error, done}); else pass++;
    total++;
    if (wcount - w0 !== 2) $display("FAIL chk_count got %0d want 2", wcount - w0); else pass++;
    @(negedge clk);
  endtask
`endif

  task automatic test_reset_mid;
    bq_t q;
    int cyc, w0;
    q = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
    w0 = wcount;
    load(with_chk(q), 1'b0, 1'b0, 7, cyc);
    total++;
    if ({byte_ready, mem_w_en, busy, cpu_hold, done, error, mem_addr, mem_d_in} !== 31'h0)
      $display("FAIL mid_outputs got %h want 0", {byte_ready, mem_w_en, busy, cpu_hold, done, error, mem_addr, mem_d_in});
    else pass++;
    total++;
    if (wcount - w0 !== 1) $display("FAIL mid_writes got %0d want 1", wcount - w0); else pass++;
    @(negedge clk); rst_n = 1'b1;
    q = '{8'h00, 8'h01, 8'hBE, 8'hEF};
    w0 = wcount;
    load(with_chk(q), 1'b0, 1'b0, 0, cyc);
    total++;
    if (cyc !== 6 + CK) $display("FAIL mid_reload_latency got %0d want %0d", cyc, 6 + CK); else pass++;
    total++;
    if ({wcount - w0 == 1, wa[w0], wd[w0], done} !== {1'b1, 9'd0, 16'hBEEF, 1'b1})
      $display("FAIL mid_reload got n=%0d %h:%h done=%b want n=1 0:beef done=1", wcount - w0, wa[w0], wd[w0], done);
    else pass++;
  endtask

  initial begin
    test_reset;
    test_two_words;
    test_backpressure;
    test_oversize;
    test_full;
`ifdef LOADER_CHECKSUM_EN
    test_bad_checksum;
`endif
    test_reset_mid;
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
